// File: rtl/ac_in.sv
// Accumulator input register: captures newData when accept is high and
// reports whether anything was ever loaded, whether it was reloaded, and whether the value moved.
module ac_in #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] newData,
   input  logic             accept,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             updated,
   output logic             changed
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             updated_q, updated_d;
   logic             changed_q, changed_d;

   // newData is only looked at under accept, so an unknown value on it cannot leak out while idle.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      updated_d = 1'b0;
      changed_d = 1'b0;
      if (accept) begin
         data_d    = newData;
         valid_d   = 1'b1;
         updated_d = 1'b1;
         changed_d = (newData != data_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         updated_q <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         updated_q <= updated_d;
         changed_q <= changed_d;
      end
   end

   assign data    = data_q;
   assign valid   = valid_q;
   assign updated = updated_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_ac_in.sv
// Self-checking bench for ac_in: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ac_in;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] newData;
   logic             accept;
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             updated;
   logic             changed;

   int errors = 0;
   int checks = 0;

   ac_in #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .newData (newData),
      .accept  (accept),
      .data    (data),
      .valid   (valid),
      .updated (updated),
      .changed (changed)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: what the outputs must show after each edge.
   logic [WIDTH-1:0] m_data;
   logic             m_valid, m_updated, m_changed;
   bit               m_known = 0;

   always @(posedge clk) begin
      if (rst_n === 1'b0) begin
         m_data    = '0;
         m_valid   = 1'b0;
         m_updated = 1'b0;
         m_changed = 1'b0;
         m_known   = 1;
      end else if (accept === 1'b1) begin
         m_changed = (newData !== m_data);
         m_updated = 1'b1;
         m_valid   = 1'b1;
         m_data    = newData;
      end else begin
         m_updated = 1'b0;
         m_changed = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process: every cycle once the model state is defined
   always @(posedge clk) begin
      #2;
      if (m_known) begin
         chk("model_data",    32'(data),    32'(m_data));
         chk("model_valid",   32'(valid),   32'(m_valid));
         chk("model_updated", 32'(updated), 32'(m_updated));
         chk("model_changed", 32'(changed), 32'(m_changed));
      end
   end

   // driver: present inputs on the falling edge, return just after the next rising edge
   task automatic step(input logic r, input logic a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      rst_n   = r;
      accept  = a;
      newData = d;
      @(posedge clk);
      #3;
   endtask

   task automatic expect_all(input string tag, input logic [WIDTH-1:0] d,
                             input logic v, input logic u, input logic c);
      chk({tag, "_data"},    32'(data),    32'(d));
      chk({tag, "_valid"},   32'(valid),   32'(v));
      chk({tag, "_updated"}, 32'(updated), 32'(u));
      chk({tag, "_changed"}, 32'(changed), 32'(c));
   endtask

   initial begin
      rst_n = 1'b0; accept = 1'b0; newData = '0;

      // reset for two cycles
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      expect_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

      step(1'b1, 1'b1, 8'h01);
      expect_all("load01", 8'h01, 1'b1, 1'b1, 1'b1);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 8'h02);
         expect_all("hold", 8'h01, 1'b1, 1'b0, 1'b0);
      end

      step(1'b1, 1'b1, 8'h04);
      expect_all("b2b_04", 8'h04, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 8'h05);
      expect_all("b2b_05", 8'h05, 1'b1, 1'b1, 1'b1);

      step(1'b1, 1'b1, 8'h05);
      expect_all("same05", 8'h05, 1'b1, 1'b1, 1'b0);

      // unknown newData while idle must not disturb anything
      step(1'b1, 1'b0, 'x);
      expect_all("idle_x", 8'h05, 1'b1, 1'b0, 1'b0);

      // reset pulse between edges is ignored
      @(negedge clk);
      accept = 1'b0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #3;
      expect_all("glitch", 8'h05, 1'b1, 1'b0, 1'b0);

      step(1'b0, 1'b1, 8'hFF);
      expect_all("rst_pri", 8'h00, 1'b0, 1'b0, 1'b0);

      // first load after reset with a value equal to the cleared data
      step(1'b1, 1'b1, 8'h00);
      expect_all("post_rst", 8'h00, 1'b1, 1'b1, 1'b0);

      step(1'b1, 1'b1, 8'hA5);
      expect_all("full_w", 8'hA5, 1'b1, 1'b1, 1'b1);

      // randomized traffic, model checked every cycle
      for (int i = 0; i < 400; i++) begin
         logic r, a;
         logic [WIDTH-1:0] d;
         r = ($urandom_range(0, 29) != 0);
         a = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       d = m_data;
            1:       d = WIDTH'($urandom_range(0, 3));
            default: d = WIDTH'($urandom);
         endcase
         step(r, a, d);
      end

      step(1'b1, 1'b0, 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ac_in.md
AC_IN -- requirements
Module: ac_in

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the data path.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: newData  input  WIDTH  candidate value to capture into the accumulator input register.
REQ-005 Port: accept  input  1  load enable; when high, newData is captured.
REQ-006 Port: data  output  WIDTH  registered accumulator input value.
REQ-007 Port: valid  output  1  high once at least one value has been captured since reset.
REQ-008 Port: updated  output  1  one-cycle pulse marking that data was (re)loaded on the previous edge.
REQ-009 Port: changed  output  1  one-cycle pulse marking that the last load altered the value of data.

Function
REQ-010 On a rising edge of clk with rst_n=1 and accept=1, data SHALL take the value of newData; the new value is visible on data immediately after that edge (1-cycle latency).
REQ-011 On a rising edge with rst_n=1 and accept=0, data SHALL hold its previous value regardless of newData.
REQ-012 data SHALL be driven only from the register, never combinationally from newData or accept.
REQ-013 valid SHALL go high on the first edge where a load occurs and stay high until reset.
REQ-014 updated SHALL be 1 for exactly the cycle after each edge where a load occurs, else 0; back-to-back loads keep it high continuously.
REQ-015 changed SHALL be 1 for the cycle after a load where newData differed from the prior data value, else 0.
REQ-016 Loading a value equal to the current data SHALL assert updated but not changed.
REQ-017 Data SHALL be captured at full WIDTH with no truncation, sign extension or arithmetic.
REQ-018 X or unknown on newData while accept=0 SHALL NOT affect any output.

Reset
REQ-019 When rst_n=0 at a rising edge of clk, data SHALL become all zeros and valid, updated and changed SHALL become 0.
REQ-020 Reset SHALL take priority over accept: a load requested in the same edge as reset is discarded.
REQ-021 Assertion or deassertion of rst_n between clock edges SHALL have no effect until the next rising edge.
REQ-022 After rst_n returns high, the first edge with accept=1 SHALL load normally.

Verification
REQ-023 Reset for 2 cycles -> data=0x00, valid=0, updated=0, changed=0.
REQ-024 newData=0x01, accept=1, one edge -> data=0x01, valid=1, updated=1, changed=1.
REQ-025 newData=0x02, accept=0, several edges -> data stays 0x01, updated=0, changed=0.
REQ-026 newData=0x04, accept=1, then newData=0x05, accept=1 on the next edge -> data=0x04 then 0x05, updated high both cycles.
REQ-027 accept=1 with newData equal to the current data (0x05) -> data=0x05, updated=1, changed=0.
REQ-028 rst_n=0 and accept=1 with newData=0xFF on the same edge -> data=0x00, valid=0.
